ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Drives the configuration-chain head (ccff_head) that feeds the logic-tile configuration memories, including the flip-flop mode memories, from a word-wide write port.
- Serialises each configuration word LSB-first onto the chain, one bit per prog_clk cycle, with a chain shift enable.
- Captures the bit emerging at the far end of the chain (ccff_tail) on every shift cycle and returns it as readback words, so software can verify the previous contents.
- Sits between the SoC configuration interface and the first tile of the fabric's configuration chain.

Parameters:
- WORD_W, 32, width of write and readback words (≥2).
- LEN_W, 20, width of the bit-length counter; maximum chain length is 2^LEN_W-1 bits.

Ports:
- prog_clk  input  1  configuration clock; all state changes on rising edge.
- pReset_n  input  1  asynchronous active-low reset.
- cfg_start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- cfg_len  input  LEN_W  number of chain bits to shift; sampled when cfg_start is accepted.
- wr_data  input  WORD_W  configuration word; bit 0 is shifted first.
- wr_valid  input  1  wr_data valid.
- wr_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data into the chain.
- ccff_shift_en  output  1  chain shifts on this prog_clk edge when high.
- ccff_tail  input  1  serial data out of the chain end.
- rd_data  output  WORD_W  readback word; bit k is the k-th tail bit captured within that word.
- rd_valid  output  1  one-cycle pulse; rd_data valid. No backpressure.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load completes.

Behaviour:
- Reset state: IDLE. All outputs are 0 during reset: wr_ready, ccff_head, ccff_shift_en, rd_data, rd_valid, busy, done. All counters and shift registers are cleared. Reset asserted mid-load aborts immediately, with no done pulse; chain contents are then undefined.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cfg_start with cfg_len=0 goes to DONE.
  - cfg_start with cfg_len>0 latches remaining=cfg_len, clears bit index, and goes to LOAD.
- LOAD:
  - wr_ready=1.
  - On wr_valid&wr_ready: sreg<=wr_data, bit index<=0, rb<=0, go to SHIFT.
  - No handshake means the FSM stays in LOAD with ccff_shift_en=0 (chain holds).
- SHIFT:
  - ccff_shift_en=1 and ccff_head=sreg[0], both derived combinationally from registered state.
  - Each cycle: rb[idx]<=ccff_tail, sreg>>=1, idx++, remaining--.
  - If remaining==1: pulse rd_valid next cycle with the partial word (unfilled bits 0), then go to DONE.
  - Else if idx==WORD_W-1: pulse rd_valid next cycle, then go to LOAD.
  - wr_ready=0 in SHIFT.
- Excess wr_data bits beyond cfg_len in the last word are never shifted.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in LOAD, SHIFT, DONE.
- cfg_start outside IDLE is ignored; cfg_len changes after acceptance have no effect.
- Latency:
  - cfg_start → wr_ready high on the next cycle.
  - Handshake → first shift_en cycle is the next cycle.
  - Per word: WORD_W shift cycles plus ≥1 LOAD cycle.
  - Last shift → done on the next cycle, coincident with the final rd_valid.
- Counter wrap: remaining never underflows; the SHIFT exit is tested before decrementing past 1.

Test Plan:
- cfg_len=5, word 0x15 → shift_en high 5 consecutive cycles; ccff_head sequence 1,0,1,0,1; done pulses the cycle after; exactly one rd_valid.
- Behavioural 5-bit chain model preloaded 0b10110, load 0x0F with cfg_len=5 → rd_data=0x16; chain now holds 0x0F (bit 0 at tail).
- cfg_len=70, WORD_W=32, wr_valid held high → 70 shift cycles total, as 32, 32 and 6 separated by one LOAD cycle each; rd_valid fires 3 times with the last word's bits 6..31=0; done once.
- wr_valid withheld 10 cycles mid-load → shift_en stays 0 and ccff_head does not advance; load resumes correctly.
- cfg_len=0 → busy for 1 cycle, done pulse, no wr_ready, no shift_en, no rd_valid; cfg_start during SHIFT is ignored.
- pReset_n asserted during SHIFT → all outputs 0 asynchronously, no done; a new cfg_start after release loads normally.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises configuration words LSB-first onto
// the fabric configuration chain and returns the bits that fall out of the
// chain tail as readback words.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for cfg_start
// ST_LOAD  | wr_ready high, waiting for the next configuration word
// ST_SHIFT | one chain bit per cycle, tail bit captured into readback
// ST_DONE  | one-cycle done pulse, then back to idle
module ccff_bitstream_loader #(
   parameter int WORD_W = 32,
   parameter int LEN_W  = 20
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              cfg_start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   input  logic              ccff_tail,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t            state;
   logic [LEN_W-1:0]  remaining;
   logic [IDX_W-1:0]  idx;
   logic [WORD_W-1:0] sreg;
   logic [WORD_W-1:0] rb;
   logic [WORD_W-1:0] rb_next;
   logic              last_bit;
   logic              word_full;

   // Readback word including the tail bit captured this cycle, so the word
   // handed out on exit from SHIFT already contains its final bit.
   always_comb begin
      rb_next      = rb;
      rb_next[idx] = ccff_tail;
   end

   // remaining is the down-counter of chain bits still to go; terminal count
   // is 1 so the exit is taken before it could wrap past zero.
   assign last_bit  = (remaining == LEN_W'(1));
   assign word_full = (idx == IDX_W'(WORD_W - 1));

   // Loader FSM with its datapath registers.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state     <= ST_IDLE;
         remaining <= '0;
         idx       <= '0;
         sreg      <= '0;
         rb        <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  if (cfg_len == '0) begin
                     state <= ST_DONE;
                  end else begin
                     remaining <= cfg_len;
                     idx       <= '0;
                     state     <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (wr_valid) begin
                  sreg  <= wr_data;
                  idx   <= '0;
                  rb    <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               rb        <= rb_next;
               sreg      <= sreg >> 1;
               idx       <= idx + IDX_W'(1);
               remaining <= remaining - LEN_W'(1);
               if (last_bit) begin
                  rd_data  <= rb_next;
                  rd_valid <= 1'b1;
                  state    <= ST_DONE;
               end else if (word_full) begin
                  rd_data  <= rb_next;
                  rd_valid <= 1'b1;
                  state    <= ST_LOAD;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Handshake and chain controls depend only on the registered state, so
   // they are glitch-free and all read 0 while reset holds the FSM in idle.
   assign wr_ready      = (state == ST_LOAD);
   assign ccff_shift_en = (state == ST_SHIFT);
   assign ccff_head     = ccff_shift_en & sreg[0];
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: behavioural chain model on the tail,
// expected head bits / readback words / per-load cycle counts queued by the
// stimulus and consumed by an independent monitor.
module tb_ccff_bitstream_loader;

   localparam int WORD_W = 32;
   localparam int LEN_W  = 20;

   logic              prog_clk;
   logic              pReset_n;
   logic              cfg_start;
   logic [LEN_W-1:0]  cfg_len;
   logic [WORD_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              ccff_head;
   logic              ccff_shift_en;
   logic              ccff_tail;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              busy;
   logic              done;

   ccff_bitstream_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
      .prog_clk      (prog_clk),
      .pReset_n      (pReset_n),
      .cfg_start     (cfg_start),
      .cfg_len       (cfg_len),
      .wr_data       (wr_data),
      .wr_valid      (wr_valid),
      .wr_ready      (wr_ready),
      .ccff_head     (ccff_head),
      .ccff_shift_en (ccff_shift_en),
      .ccff_tail     (ccff_tail),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .busy          (busy),
      .done          (done)
   );

   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   // chain model: bit 0 is the tail, new bits enter at bit chain_len-1
   logic [127:0] chain;
   logic [127:0] preload_val;
   logic         preload_req;
   int           chain_len;

   assign ccff_tail = chain[0];

   always @(posedge prog_clk) begin
      if (preload_req)
         chain <= preload_val;
      else if (ccff_shift_en)
         chain <= (chain >> 1) | (128'(ccff_head) << (chain_len - 1));
   end

   typedef struct {
      int shifts;
      int busy_cyc;
   } load_rec_t;

   logic      head_q[$];
   logic [31:0] rd_q[$];
   load_rec_t ld_q[$];

   int total;
   int bad;
   int done_seen;
   int shift_cnt;
   int busy_cnt;

   logic [31:0] words[4];
   logic [31:0] rdexp[4];

   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(string nm);
      total++;
      bad++;
      $display("FAIL %s t=%0t", nm, $time);
   endfunction

   // monitor: consumes expectations whenever the DUT presents output
   initial begin
      load_rec_t r;
      shift_cnt = 0;
      busy_cnt  = 0;
      done_seen = 0;
      forever begin
         @(negedge prog_clk);
         if (!pReset_n) begin
            shift_cnt = 0;
            busy_cnt  = 0;
         end else begin
            if (ccff_shift_en) begin
               shift_cnt++;
               if (head_q.size() == 0) fail_now("head_unexpected");
               else check("head_bit", 64'(ccff_head), 64'(head_q.pop_front()));
            end
            if (busy) busy_cnt++;
            if (rd_valid) begin
               if (rd_q.size() == 0) fail_now("rd_valid_unexpected");
               else check("rd_data", 64'(rd_data), 64'(rd_q.pop_front()));
            end
            if (done) begin
               done_seen++;
               if (ld_q.size() == 0) fail_now("done_unexpected");
               else begin
                  r = ld_q.pop_front();
                  check("shift_cycles", 64'(shift_cnt), 64'(r.shifts));
                  check("busy_cycles", 64'(busy_cnt), 64'(r.busy_cyc));
                  if (r.shifts > 0) check("done_with_rd_valid", 64'(rd_valid), 64'd1);
               end
               shift_cnt = 0;
               busy_cnt  = 0;
            end
         end
      end
   end

   task automatic preload(input int len, input logic [127:0] v);
      @(negedge prog_clk);
      chain_len   = len;
      preload_val = v;
      preload_req = 1'b1;
      @(posedge prog_clk);
      #1 preload_req = 1'b0;
   endtask

   // words[] carries the data, rdexp[] the hand-computed readback words
   task automatic do_load(input int len, input int nwords, input int gap_idx,
                          input int gap, input int exp_busy);
      load_rec_t r;
      int rem;
      int n;
      rem = len;
      for (int i = 0; i < nwords; i++)
         for (int b = 0; b < 32; b++)
            if (rem > 0) begin
               head_q.push_back(words[i][b]);
               rem--;
            end
      for (int i = 0; i < (len + 31) / 32; i++) rd_q.push_back(rdexp[i]);
      r.shifts   = len;
      r.busy_cyc = exp_busy;
      ld_q.push_back(r);

      @(negedge prog_clk);
      cfg_len   = LEN_W'(len);
      cfg_start = 1'b1;
      wr_data   = words[0];
      wr_valid  = !(gap_idx == 0 && gap > 0);
      @(posedge prog_clk);
      #1 cfg_start = 1'b0;
      for (int i = 0; i < nwords; i++) begin
         n = 0;
         @(negedge prog_clk);
         while (!wr_ready && n < 200) begin
            @(negedge prog_clk);
            n++;
         end
         if (!wr_ready) begin
            fail_now("timeout_wr_ready");
            return;
         end
         if (i == gap_idx && gap > 0) begin
            for (int k = 0; k < gap; k++) begin
               check("hold_shift_en", 64'(ccff_shift_en), 64'd0);
               check("hold_head", 64'(ccff_head), 64'd0);
               check("hold_wr_ready", 64'(wr_ready), 64'd1);
               @(negedge prog_clk);
            end
         end
         wr_data  = words[i];
         wr_valid = 1'b1;
         @(posedge prog_clk);
         #1;
         if (i + 1 < nwords) begin
            wr_data  = words[i+1];
            wr_valid = !(i + 1 == gap_idx && gap > 0);
         end else begin
            wr_valid = 1'b0;
         end
      end
      n = 0;
      while (busy && n < 300) begin
         @(negedge prog_clk);
         n++;
      end
      if (busy) fail_now("timeout_done");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      total       = 0;
      bad         = 0;
      pReset_n    = 1'b0;
      cfg_start   = 1'b0;
      cfg_len     = '0;
      wr_data     = '0;
      wr_valid    = 1'b0;
      preload_req = 1'b0;
      preload_val = '0;
      chain_len   = 5;
      chain       = '0;

      // reset state
      repeat (3) @(negedge prog_clk);
      check("rst_wr_ready", 64'(wr_ready), 64'd0);
      check("rst_shift_en", 64'(ccff_shift_en), 64'd0);
      check("rst_head", 64'(ccff_head), 64'd0);
      check("rst_rd_data", 64'(rd_data), 64'd0);
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      pReset_n = 1'b1;

      // 5-bit chain preloaded 10110, load 0x15
      preload(5, 128'h16);
      words[0] = 32'h15;
      rdexp[0] = 32'h16;
      do_load(5, 1, -1, 0, 7);

      // reload 0x0F: readback is the previous 0x15, chain ends up 0x0F
      words[0] = 32'h0F;
      rdexp[0] = 32'h15;
      do_load(5, 1, -1, 0, 7);
      check("chain_after_0f", 64'(chain[4:0]), 64'h0F);

      // 70-bit chain, three words back to back, excess bits in last word
      preload(70, {58'd0, 6'h2A, 32'hDEADBEEF, 32'h12345678});
      words[0] = 32'hCAFEF00D;
      words[1] = 32'h0BADC0DE;
      words[2] = 32'hFFFFFFC5;
      rdexp[0] = 32'h12345678;
      rdexp[1] = 32'hDEADBEEF;
      rdexp[2] = 32'h0000002A;
      do_load(70, 3, -1, 0, 74);
      check("chain_after_70", 64'(chain[69:64]), 64'h05);

      // same chain, second word withheld 10 cycles
      words[0] = 32'h11111111;
      words[1] = 32'h22222222;
      words[2] = 32'h0000003F;
      rdexp[0] = 32'hCAFEF00D;
      rdexp[1] = 32'h0BADC0DE;
      rdexp[2] = 32'h00000005;
      do_load(70, 3, 1, 10, 84);

      // zero-length load
      begin
         load_rec_t r0;
         r0.shifts   = 0;
         r0.busy_cyc = 1;
         ld_q.push_back(r0);
         @(negedge prog_clk);
         cfg_len   = '0;
         cfg_start = 1'b1;
         @(posedge prog_clk);
         #1 cfg_start = 1'b0;
         @(negedge prog_clk);
         check("len0_busy", 64'(busy), 64'd1);
         check("len0_done", 64'(done), 64'd1);
         check("len0_wr_ready", 64'(wr_ready), 64'd0);
         check("len0_shift_en", 64'(ccff_shift_en), 64'd0);
         check("len0_rd_valid", 64'(rd_valid), 64'd0);
         @(negedge prog_clk);
         check("len0_idle", 64'(busy), 64'd0);
      end

      // cfg_start during SHIFT is ignored
      preload(5, 128'h19);
      words[0] = 32'h0A;
      rdexp[0] = 32'h19;
      fork
         do_load(5, 1, -1, 0, 7);
         begin
            repeat (4) @(negedge prog_clk);
            check("start_in_shift", 64'(ccff_shift_en), 64'd1);
            cfg_len   = '0;
            cfg_start = 1'b1;
            @(negedge prog_clk);
            cfg_start = 1'b0;
         end
      join

      // asynchronous reset in the middle of SHIFT
      preload(8, 128'h0);
      for (int b = 0; b < 8; b++) head_q.push_back(b[0] ? 1'b0 : (b == 0 || b == 2 || b == 5 || b == 7));
      @(negedge prog_clk);
      cfg_len   = LEN_W'(8);
      cfg_start = 1'b1;
      wr_data   = 32'hA5;
      wr_valid  = 1'b1;
      @(posedge prog_clk);
      #1 cfg_start = 1'b0;
      @(posedge prog_clk);
      #1 wr_valid = 1'b0;
      repeat (3) @(negedge prog_clk);
      check("pre_rst_shift_en", 64'(ccff_shift_en), 64'd1);
      #2 pReset_n = 1'b0;
      #1;
      check("arst_wr_ready", 64'(wr_ready), 64'd0);
      check("arst_shift_en", 64'(ccff_shift_en), 64'd0);
      check("arst_head", 64'(ccff_head), 64'd0);
      check("arst_rd_data", 64'(rd_data), 64'd0);
      check("arst_rd_valid", 64'(rd_valid), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      head_q.delete();
      rd_q.delete();
      ld_q.delete();
      repeat (2) @(negedge prog_clk);
      pReset_n = 1'b1;

      // normal load after reset release
      preload(8, 128'h3C);
      words[0] = 32'h5A;
      rdexp[0] = 32'h3C;
      do_load(8, 1, -1, 0, 10);
      check("chain_after_5a", 64'(chain[7:0]), 64'h5A);

      repeat (3) @(negedge prog_clk);
      check("head_q_left", 64'(head_q.size()), 64'd0);
      check("rd_q_left", 64'(rd_q.size()), 64'd0);
      check("ld_q_left", 64'(ld_q.size()), 64'd0);
      check("done_count", 64'(done_seen), 64'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
